ll_rx_auto_align: RTL and testbench
===================================

# ll_rx_auto_align

Receive-side counterpart of the logic-link TX auto-sync. It watches the incoming user marker and strobe bits on each received word and finds the marker cadence. It then captures the phase of the one-shot strobe relative to that cadence and verifies the cadence over several periods. Once verified it declares lock to the RX logic-link/online-delay path. It sits between the PHY/word-aligner output and the logic-link RX FIFO control, in the clk_wr domain.

## Interface
Parameters:
- MARKER_WIDTH, 1, width of the user marker field per word
- MARKER_PERIOD, 4, valid words per marker period (legal 2..16)
- NO_MARKER, 1'b0, 1 = strobe bit doubles as marker (no marker field in use)
- PERSISTENT_MARKER, 1'b1, 0 = transmitter stops sending markers after sync, so no marker checking once LOCKED
- LOCK_COUNT, 3, consecutive correct marker periods required for lock (1..15)
- UNLOCK_COUNT, 2, consecutive bad marker periods that drop lock (1..15)

Ports:
- clk_wr  in  1  receive word clock
- rst_wr_n  in  1  reset; asynchronous, active-low
- rx_enable  in  1  PHY word alignment done; 0 forces IDLE
- rx_word_valid  in  1  a received word is present this cycle
- rx_mrk_userbit  in  MARKER_WIDTH  received marker bits
- rx_stb_userbit  in  1  received strobe bit
- rx_marker_lock  out  1  cadence verified, level
- rx_strobe_seen  out  1  strobe phase captured, level
- rx_strobe_phase  out  4  phase index (0..MARKER_PERIOD-1) of the captured strobe
- rx_sync_error  out  1  one-cycle pulse on any cadence violation
- rx_error_count  out  8  saturating count of rx_sync_error pulses

## Operation
- Marker event (mk): NO_MARKER=0 → rx_word_valid & |rx_mrk_userbit; NO_MARKER=1 → rx_word_valid & rx_stb_userbit.
- Strobe event (sk): rx_word_valid & rx_stb_userbit.
- phase counter, 4 bits:
  - forced to 0 on a word carrying an accepted marker;
  - otherwise increments on each valid word, wrapping MARKER_PERIOD-1 → 0;
  - holds when rx_word_valid=0.
- Expected-marker word: a valid word whose phase, before the update, is MARKER_PERIOD-1, i.e. the next position is 0.
- States:
  - IDLE: all level outputs 0. Goes to HUNT when rx_enable=1.
  - HUNT: on mk, load phase to 0 and go to STB_WAIT. When NO_MARKER=1, the same word is also the strobe: capture phase 0, set rx_strobe_seen, go to VERIFY.
  - STB_WAIT: on sk (NO_MARKER=0) at a non-marker position, capture the current word's phase, set rx_strobe_seen, go to VERIFY. A correctly placed mk is accepted and stays in STB_WAIT. An mk off phase 0, or a missing mk at an expected position, is an error.
  - VERIFY: good_cnt increments on each correct expected marker. Reaching LOCK_COUNT → LOCKED. Any violation is an error. An sk at a phase other than rx_strobe_phase is also an error, which tolerates a persistent strobe.
  - LOCKED: rx_marker_lock=1.
    - PERSISTENT_MARKER=1: a bad period (missing or misplaced mk) increments bad_cnt and a good one clears it. bad_cnt reaching UNLOCK_COUNT is an error.
    - PERSISTENT_MARKER=0: no checking; lock holds until rx_enable falls.
- Error action:
  - pulse rx_sync_error for 1 cycle and increment rx_error_count (saturates at 8'hFF);
  - go to HUNT and clear rx_strobe_seen, rx_strobe_phase, rx_marker_lock, good_cnt and bad_cnt;
  - the offending word is not reused as a new hunt marker.
- rx_enable=0 in any state: IDLE next cycle, all level outputs cleared, no error pulse. rx_error_count is retained.
- rx_error_count is cleared only by reset.

## Timing
- All outputs are registered.
- Reset values: rx_marker_lock=0, rx_strobe_seen=0, rx_strobe_phase=0, rx_sync_error=0, rx_error_count=0, state IDLE.
- IDLE→HUNT: one cycle after rx_enable rises.
- rx_strobe_seen: high the cycle after the strobe word is sampled.
- rx_marker_lock: high the cycle after the LOCK_COUNT-th correct marker word is sampled.
- rx_sync_error: high the cycle after the violating word is sampled. The state is HUNT in that same cycle.
- Words with rx_word_valid=0 do not advance any counter or state.
- Simultaneous rx_enable fall and violation: rx_enable wins and no error pulse is generated.
- Asynchronous reset mid-lock: all outputs drop immediately.

## Test plan
- MARKER_PERIOD=4, LOCK_COUNT=3, markers every 4th valid word, strobe on phase 2 after the first marker → rx_strobe_seen=1, rx_strobe_phase=2, rx_marker_lock=1 one cycle after the 3rd verified marker.
- Locked; marker moved to phase 1 for two periods (UNLOCK_COUNT=2) → one rx_sync_error pulse, lock drops, rx_error_count=1, state HUNT; restoring cadence relocks.
- PERSISTENT_MARKER=0; markers stop after lock → rx_marker_lock stays 1; drop rx_enable → all levels 0 next cycle, no error pulse.
- Gaps of rx_word_valid=0 inserted randomly between words of a correct stream → identical lock and phase results to the gap-free run.
- In STB_WAIT, a marker arrives at phase 3 → error pulse, return to HUNT, rx_strobe_seen stays 0.
- Drive 300 forced errors → rx_error_count saturates at 255; assert reset mid-stream → all outputs 0 immediately.

Source files
------------

// File: rtl/ll_rx_auto_align.sv
// ll_rx_auto_align: receive-side marker cadence finder.
// Hunts for the user marker and captures the strobe phase relative to it.
// Verifies the cadence for a number of periods, then declares lock.
// Any cadence violation pulses rx_sync_error and sends the block back to
// hunting; the error count saturates and is cleared only by reset.
module ll_rx_auto_align #(
    parameter int MARKER_WIDTH      = 1,
    parameter int MARKER_PERIOD     = 4,
    parameter bit NO_MARKER         = 1'b0,
    parameter bit PERSISTENT_MARKER = 1'b1,
    parameter int LOCK_COUNT        = 3,
    parameter int UNLOCK_COUNT      = 2
) (
    input  logic                    clk_wr,
    input  logic                    rst_wr_n,
    input  logic                    rx_enable,
    input  logic                    rx_word_valid,
    input  logic [MARKER_WIDTH-1:0] rx_mrk_userbit,
    input  logic                    rx_stb_userbit,
    output logic                    rx_marker_lock,
    output logic                    rx_strobe_seen,
    output logic [3:0]              rx_strobe_phase,
    output logic                    rx_sync_error,
    output logic [7:0]              rx_error_count
);

    localparam logic [3:0] PHASE_LAST = 4'(MARKER_PERIOD - 1);
    localparam logic [3:0] GOOD_LAST  = 4'(LOCK_COUNT - 1);
    localparam logic [3:0] BAD_LAST   = 4'(UNLOCK_COUNT - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_HUNT     = 3'd1,
        S_STB_WAIT = 3'd2,
        S_VERIFY   = 3'd3,
        S_LOCKED   = 3'd4
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] phase;
    logic [3:0] word_phase;
    logic [3:0] good_cnt;
    logic [3:0] bad_cnt;
    logic       period_bad;
    logic       mk;
    logic       sk;
    logic       exp_pos;
    logic       err;
    logic       capture;
    logic [3:0] cap_phase;
    logic       good_hit;
    logic       bad_hit;
    logic       good_period;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // With NO_MARKER the strobe bit doubles as the marker.
    assign mk = rx_word_valid & (NO_MARKER ? rx_stb_userbit : |rx_mrk_userbit);
    assign sk = rx_word_valid & rx_stb_userbit;

    // A marker belongs on the word after phase MARKER_PERIOD-1.
    assign exp_pos    = rx_word_valid & (phase == PHASE_LAST);
    assign word_phase = (phase == PHASE_LAST) ? 4'd0 : phase + 4'd1;

    // State register.
    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and per-word event decode; rx_enable low overrides everything.
    always_comb begin
        state_next  = state;
        err         = 1'b0;
        capture     = 1'b0;
        cap_phase   = word_phase;
        good_hit    = 1'b0;
        bad_hit     = 1'b0;
        good_period = 1'b0;
        if (!rx_enable) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    state_next = S_HUNT;
                end
                S_HUNT: begin
                    if (mk) begin
                        if (NO_MARKER) begin
                            capture    = 1'b1;
                            cap_phase  = 4'd0;
                            state_next = S_VERIFY;
                        end else begin
                            state_next = S_STB_WAIT;
                        end
                    end
                end
                S_STB_WAIT: begin
                    // mk != exp_pos covers both a misplaced and a missing marker.
                    if (mk != exp_pos) begin
                        err = 1'b1;
                    end else if (sk && !exp_pos) begin
                        capture    = 1'b1;
                        state_next = S_VERIFY;
                    end
                end
                S_VERIFY: begin
                    if (mk != exp_pos) begin
                        err = 1'b1;
                    end else if (sk && (word_phase != rx_strobe_phase)) begin
                        err = 1'b1;
                    end else if (mk) begin
                        good_hit = 1'b1;
                        if (good_cnt == GOOD_LAST) begin
                            state_next = S_LOCKED;
                        end
                    end
                end
                S_LOCKED: begin
                    // A period is judged at its expected marker position.
                    if (PERSISTENT_MARKER && exp_pos) begin
                        if (mk && !period_bad) begin
                            good_period = 1'b1;
                        end else begin
                            bad_hit = 1'b1;
                            if (bad_cnt == BAD_LAST) begin
                                err = 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
            if (err) begin
                state_next = S_HUNT;
            end
        end
    end

    // Level outputs decoded straight from the state register.
    always_comb begin
        rx_marker_lock = (state == S_LOCKED);
        rx_strobe_seen = (state == S_VERIFY) || (state == S_LOCKED);
    end

    // Phase counter, strobe phase, period counters and the error pulse/count.
    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            phase           <= 4'd0;
            rx_strobe_phase <= 4'd0;
            good_cnt        <= 4'd0;
            bad_cnt         <= 4'd0;
            period_bad      <= 1'b0;
            rx_sync_error   <= 1'b0;
            rx_error_count  <= 8'd0;
        end else begin
            rx_sync_error <= err;
            if (err) begin
                rx_error_count <= sat_inc8(rx_error_count);
            end

            if (!rx_enable || (state == S_IDLE)) begin
                phase <= 4'd0;
            end else if (rx_word_valid) begin
                phase <= (state == S_HUNT && mk) ? 4'd0 : word_phase;
            end

            if (!rx_enable || err) begin
                rx_strobe_phase <= 4'd0;
            end else if (capture) begin
                rx_strobe_phase <= cap_phase;
            end

            if (state != S_VERIFY) begin
                good_cnt <= 4'd0;
            end else if (good_hit) begin
                good_cnt <= good_cnt + 4'd1;
            end

            if (state != S_LOCKED) begin
                bad_cnt <= 4'd0;
            end else if (bad_hit) begin
                bad_cnt <= bad_cnt + 4'd1;
            end else if (good_period) begin
                bad_cnt <= 4'd0;
            end

            if (state != S_LOCKED) begin
                period_bad <= 1'b0;
            end else if (rx_word_valid) begin
                if (exp_pos) begin
                    period_bad <= 1'b0;
                end else if (mk) begin
                    period_bad <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ll_rx_auto_align.sv
// Testbench for ll_rx_auto_align: scenario streams with expected events per word.
module tb_ll_rx_auto_align;

    logic clk_wr = 1'b0;
    always #5 clk_wr = ~clk_wr;

    logic       rst_wr_n;
    logic       en_a;
    logic       en_b;
    logic       valid;
    logic       stb;
    logic [0:0] mrk;
    logic       lock_a, seen_a, err_a, lock_b, seen_b, err_b;
    logic [3:0] ph_a, ph_b;
    logic [7:0] cnt_a, cnt_b;

    logic        sel_b;
    logic        gaps_on;
    logic [14:0] obs;
    int          total;
    int          bad;

    // Behavioural expectation: levels and count as seen from outside.
    logic       m_seen;
    logic       m_lock;
    logic [3:0] m_phase;
    logic [7:0] m_cnt;

    localparam int EV_NONE = 0;
    localparam int EV_STB  = 1;
    localparam int EV_LOCK = 2;
    localparam int EV_ERR  = 3;

    logic qm[$];
    logic qs[$];
    int   qe[$];

    ll_rx_auto_align u_a (
        .clk_wr         (clk_wr),
        .rst_wr_n       (rst_wr_n),
        .rx_enable      (en_a),
        .rx_word_valid  (valid),
        .rx_mrk_userbit (mrk),
        .rx_stb_userbit (stb),
        .rx_marker_lock (lock_a),
        .rx_strobe_seen (seen_a),
        .rx_strobe_phase(ph_a),
        .rx_sync_error  (err_a),
        .rx_error_count (cnt_a)
    );

    ll_rx_auto_align #(.PERSISTENT_MARKER(1'b0)) u_b (
        .clk_wr         (clk_wr),
        .rst_wr_n       (rst_wr_n),
        .rx_enable      (en_b),
        .rx_word_valid  (valid),
        .rx_mrk_userbit (mrk),
        .rx_stb_userbit (stb),
        .rx_marker_lock (lock_b),
        .rx_strobe_seen (seen_b),
        .rx_strobe_phase(ph_b),
        .rx_sync_error  (err_b),
        .rx_error_count (cnt_b)
    );

    assign obs = sel_b ? {seen_b, lock_b, ph_b, err_b, cnt_b}
                       : {seen_a, lock_a, ph_a, err_a, cnt_a};

    function automatic logic [14:0] expv(input logic e);
        return {m_seen, m_lock, m_phase, e, m_cnt};
    endfunction

    task automatic model_apply(input int ev, input int p);
        case (ev)
            EV_STB: begin
                m_seen  = 1'b1;
                m_phase = 4'(p);
            end
            EV_LOCK: m_lock = 1'b1;
            EV_ERR: begin
                m_seen  = 1'b0;
                m_lock  = 1'b0;
                m_phase = 4'd0;
                if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
            end
            default: ;
        endcase
    endtask

    task automatic model_off();
        m_seen  = 1'b0;
        m_lock  = 1'b0;
        m_phase = 4'd0;
    endtask

    task automatic push(input logic m, input logic s, input int e);
        qm.push_back(m);
        qs.push_back(s);
        qe.push_back(e);
    endtask

    task automatic clear_q();
        qm.delete();
        qs.delete();
        qe.delete();
    endtask

    // Drive one valid word (optionally preceded by idle cycles with junk bits).
    task automatic drive_word(input logic m, input logic s);
        if (gaps_on) begin
            repeat ($urandom_range(0, 2)) begin
                valid = 1'b0;
                mrk   = 1'($urandom);
                stb   = 1'($urandom);
                @(negedge clk_wr);
            end
        end
        valid = 1'b1;
        mrk   = m;
        stb   = s;
        @(negedge clk_wr);
        valid = 1'b0;
        mrk   = 1'b0;
        stb   = 1'b0;
    endtask

    task automatic set_en(input logic v);
        if (sel_b) en_b = v;
        else       en_a = v;
        valid = 1'b0;
        mrk   = 1'b0;
        stb   = 1'b0;
        @(negedge clk_wr);
        if (!v) model_off();
    endtask

    task automatic test_reset();
        @(negedge clk_wr);
        total++;
        if (obs !== expv(1'b0)) begin
            bad++;
            $display("FAIL reset_hold: got %b expected %b", obs, expv(1'b0));
        end
        rst_wr_n = 1'b1;
        drive_word(1'b1, 1'b1);
        drive_word(1'b1, 1'b0);
        total++;
        if (obs !== expv(1'b0)) begin
            bad++;
            $display("FAIL disabled_idle: got %b expected %b", obs, expv(1'b0));
        end
        set_en(1'b1);
    endtask

    // Hunt marker, strobe at phase p, then LOCK_COUNT(3) verified markers.
    task automatic test_lock(input logic gaps, input int p, input string tag);
        int   pre;
        logic persist;
        gaps_on = gaps;
        pre     = $urandom_range(0, 3);
        persist = 1'($urandom_range(0, 1));
        clear_q();
        for (int i = 0; i < pre; i++) push(1'b0, 1'b0, EV_NONE);
        push(1'b1, 1'b0, EV_NONE);
        for (int ph = 1; ph < 4; ph++) push(1'b0, ph == p, (ph == p) ? EV_STB : EV_NONE);
        for (int k = 1; k <= 3; k++) begin
            push(1'b1, 1'b0, (k == 3) ? EV_LOCK : EV_NONE);
            for (int ph = 1; ph < 4; ph++) push(1'b0, persist && (ph == p), EV_NONE);
        end
        push(1'b1, 1'b0, EV_NONE);
        for (int i = 0; i < qm.size(); i++) begin
            drive_word(qm[i], qs[i]);
            model_apply(qe[i], p);
            total++;
            if (obs !== expv(qe[i] == EV_ERR)) begin
                bad++;
                $display("FAIL lock_%s word %0d: got %b expected %b (seen,lock,phase,err,count)",
                         tag, i, obs, expv(qe[i] == EV_ERR));
            end
        end
        clear_q();
        gaps_on = 1'b0;
    endtask

    // Marker moved to phase 1 for two periods, then relock.
    task automatic test_unlock();
        clear_q();
        for (int per = 1; per <= 2; per++) begin
            push(1'b1, 1'b0, EV_NONE);
            push(1'b0, 1'b0, EV_NONE);
            push(1'b0, 1'b0, EV_NONE);
            push(1'b0, 1'b0, (per == 2) ? EV_ERR : EV_NONE);
        end
        for (int i = 0; i < qm.size(); i++) begin
            drive_word(qm[i], qs[i]);
            model_apply(qe[i], 0);
            total++;
            if (obs !== expv(qe[i] == EV_ERR)) begin
                bad++;
                $display("FAIL unlock word %0d: got %b expected %b", i, obs, expv(qe[i] == EV_ERR));
            end
        end
        clear_q();
        test_lock(1'b0, $urandom_range(1, 3), "relock");
    endtask

    task automatic test_gaps();
        set_en(1'b0);
        total++;
        if (obs !== expv(1'b0)) begin
            bad++;
            $display("FAIL gaps_disable: got %b expected %b", obs, expv(1'b0));
        end
        set_en(1'b1);
        test_lock(1'b1, $urandom_range(1, 3), "gaps1");
        set_en(1'b0);
        set_en(1'b1);
        test_lock(1'b1, $urandom_range(1, 3), "gaps2");
    endtask

    task automatic test_stbwait_err();
        set_en(1'b0);
        set_en(1'b1);
        clear_q();
        push(1'b1, 1'b0, EV_NONE);
        push(1'b0, 1'b0, EV_NONE);
        push(1'b0, 1'b0, EV_NONE);
        for (int i = 0; i < qm.size(); i++) begin
            drive_word(qm[i], qs[i]);
            model_apply(qe[i], 0);
        end
        clear_q();
        // Misplaced marker in the same cycle rx_enable falls: no error.
        en_a  = 1'b0;
        valid = 1'b1;
        mrk   = 1'b1;
        @(negedge clk_wr);
        valid = 1'b0;
        mrk   = 1'b0;
        model_off();
        total++;
        if (obs !== expv(1'b0)) begin
            bad++;
            $display("FAIL enable_beats_error: got %b expected %b", obs, expv(1'b0));
        end
        set_en(1'b1);
        push(1'b1, 1'b0, EV_NONE);
        push(1'b0, 1'b0, EV_NONE);
        push(1'b0, 1'b0, EV_NONE);
        push(1'b1, 1'b0, EV_ERR);
        // Offending marker must not start a new hunt, so this strobe is ignored.
        push(1'b0, 1'b0, EV_NONE);
        push(1'b0, 1'b1, EV_NONE);
        push(1'b0, 1'b0, EV_NONE);
        for (int i = 0; i < qm.size(); i++) begin
            drive_word(qm[i], qs[i]);
            model_apply(qe[i], 0);
            total++;
            if (obs !== expv(qe[i] == EV_ERR)) begin
                bad++;
                $display("FAIL stbwait word %0d: got %b expected %b", i, obs, expv(qe[i] == EV_ERR));
            end
        end
        clear_q();
    endtask

    task automatic test_verify_strobe_err();
        set_en(1'b0);
        set_en(1'b1);
        clear_q();
        push(1'b1, 1'b0, EV_NONE);
        push(1'b0, 1'b0, EV_NONE);
        push(1'b0, 1'b1, EV_STB);
        push(1'b0, 1'b0, EV_NONE);
        push(1'b1, 1'b0, EV_NONE);
        push(1'b0, 1'b1, EV_ERR);
        for (int i = 0; i < qm.size(); i++) begin
            drive_word(qm[i], qs[i]);
            model_apply(qe[i], 2);
            total++;
            if (obs !== expv(qe[i] == EV_ERR)) begin
                bad++;
                $display("FAIL verify_strobe word %0d: got %b expected %b", i, obs, expv(qe[i] == EV_ERR));
            end
        end
        clear_q();
    endtask

    task automatic test_nonpersistent();
        logic [7:0] saved;
        set_en(1'b0);
        saved = m_cnt;
        sel_b = 1'b1;
        m_cnt = 8'd0;
        set_en(1'b1);
        test_lock(1'b0, $urandom_range(1, 3), "np");
        clear_q();
        for (int i = 0; i < 12; i++) push(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), EV_NONE);
        for (int i = 0; i < qm.size(); i++) begin
            drive_word(qm[i], qs[i]);
            model_apply(qe[i], 0);
            total++;
            if (obs !== expv(1'b0)) begin
                bad++;
                $display("FAIL np_hold word %0d: got %b expected %b", i, obs, expv(1'b0));
            end
        end
        clear_q();
        set_en(1'b0);
        total++;
        if (obs !== expv(1'b0)) begin
            bad++;
            $display("FAIL np_disable: got %b expected %b", obs, expv(1'b0));
        end
        sel_b = 1'b0;
        m_cnt = saved;
        set_en(1'b1);
    endtask

    task automatic test_saturation();
        clear_q();
        for (int i = 0; i < 300; i++) begin
            push(1'b1, 1'b0, EV_NONE);
            push(1'b1, 1'b0, EV_ERR);
        end
        for (int i = 0; i < qm.size(); i++) begin
            drive_word(qm[i], qs[i]);
            model_apply(qe[i], 0);
            total++;
            if (obs !== expv(qe[i] == EV_ERR)) begin
                bad++;
                $display("FAIL sat word %0d: got %b expected %b", i, obs, expv(qe[i] == EV_ERR));
            end
        end
        clear_q();
        total++;
        if (obs[7:0] !== 8'd255) begin
            bad++;
            $display("FAIL sat_count: got %0d expected 255", obs[7:0]);
        end
    endtask

    task automatic test_async_reset();
        test_lock(1'b0, $urandom_range(1, 3), "prereset");
        #2;
        rst_wr_n = 1'b0;
        #1;
        model_off();
        m_cnt = 8'd0;
        total++;
        if (obs !== expv(1'b0)) begin
            bad++;
            $display("FAIL async_reset: got %b expected %b", obs, expv(1'b0));
        end
        @(negedge clk_wr);
        rst_wr_n = 1'b1;
        @(negedge clk_wr);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        sel_b    = 1'b0;
        gaps_on  = 1'b0;
        rst_wr_n = 1'b1;
        en_a     = 1'b0;
        en_b     = 1'b0;
        valid    = 1'b0;
        stb      = 1'b0;
        mrk      = 1'b0;
        m_seen   = 1'b0;
        m_lock   = 1'b0;
        m_phase  = 4'd0;
        m_cnt    = 8'd0;
        @(negedge clk_wr);
        rst_wr_n = 1'b0;
        test_reset();
        test_lock(1'b0, 2, "basic");
        test_unlock();
        test_gaps();
        test_stbwait_err();
        test_verify_strobe_err();
        test_nonpersistent();
        test_saturation();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
